// File: rtl/crc24_append.sv
// crc24_append
//   Bit-serial BLE CRC-24 generator placed ahead of the whitening stage.
//   PDU bits are forwarded with one clock of latency while the LFSR absorbs
//   them. After the last PDU bit the 24 CRC bits follow, MSB (LFSR position
//   23) first, one every BIT_PERIOD_CLK clocks; the final CRC bit carries the
//   last strobe.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   crc_state_init_bit[23:0]  CRC init value (bit 0 -> LFSR position 0)
//   crc_state_init_bit_load   strobe: latch init value
//   data_in / data_in_valid / data_in_valid_last   PDU bit stream
//   data_out / data_out_valid / data_out_valid_last  PDU + CRC bit stream
//   busy                      high while CRC bits are being emitted
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | pass PDU bits through, LFSR steps on each valid bit
// ST_CRC_OUT| shift the 24 CRC bits out, input strobes dropped
module crc24_append #(
  parameter int unsigned BIT_PERIOD_CLK         = 16,
  parameter logic [23:0] CRC_STATE_INIT_DEFAULT = 24'h555555
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] crc_state_init_bit,
  input  logic        crc_state_init_bit_load,
  input  logic        data_in,
  input  logic        data_in_valid,
  input  logic        data_in_valid_last,
  output logic        data_out,
  output logic        data_out_valid,
  output logic        data_out_valid_last,
  output logic        busy
);

  typedef enum logic {ST_IDLE, ST_CRC_OUT} state_t;

  // Feedback taps x^10+x^9+x^6+x^4+x^3+x+1 (x^24 is the shift-out term).
  localparam logic [23:0] POLY_TAPS = 24'h00065B;
  localparam logic [7:0]  PACE_TC   = 8'(BIT_PERIOD_CLK - 1);

  state_t      state, state_nxt;
  logic [23:0] init_reg, init_nxt;
  logic [23:0] lfsr, lfsr_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  pace_cnt, pace_cnt_nxt;
  logic        dout_nxt, dv_nxt, dvl_nxt, busy_nxt;

  function automatic logic [23:0] lfsr_step(input logic [23:0] s, input logic din);
    logic fb;
    fb = din ^ s[23];
    return {s[22:0], 1'b0} ^ (fb ? POLY_TAPS : 24'h0);
  endfunction

  always_comb begin
    state_nxt    = state;
    // A load is always captured by the init register; whether the LFSR
    // follows immediately depends on the state.
    init_nxt     = crc_state_init_bit_load ? crc_state_init_bit : init_reg;
    lfsr_nxt     = lfsr;
    bit_cnt_nxt  = bit_cnt;
    pace_cnt_nxt = pace_cnt;
    dout_nxt     = 1'b0;
    dv_nxt       = 1'b0;
    dvl_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (crc_state_init_bit_load) begin
          lfsr_nxt = crc_state_init_bit;
        end
        if (data_in_valid) begin
          dout_nxt = data_in;
          dv_nxt   = 1'b1;
          // A coincident load wins: the bit is forwarded but not hashed.
          if (!crc_state_init_bit_load) begin
            lfsr_nxt = lfsr_step(lfsr, data_in);
          end
          if (data_in_valid_last) begin
            state_nxt    = ST_CRC_OUT;
            bit_cnt_nxt  = 5'd0;
            pace_cnt_nxt = 8'd0;
          end
        end
      end

      ST_CRC_OUT: begin
        if (pace_cnt == PACE_TC) begin
          pace_cnt_nxt = 8'd0;
          dout_nxt     = lfsr[23];
          dv_nxt       = 1'b1;
          lfsr_nxt     = {lfsr[22:0], 1'b0};
          bit_cnt_nxt  = bit_cnt + 5'd1;
          if (bit_cnt == 5'd23) begin
            dvl_nxt   = 1'b1;
            // Uses init_nxt so a load landing on this very edge still counts.
            lfsr_nxt  = init_nxt;
            state_nxt = ST_IDLE;
          end
        end else begin
          pace_cnt_nxt = pace_cnt + 8'd1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Stays high through the cycle carrying the last CRC bit, drops one edge later.
    busy_nxt = (state == ST_CRC_OUT) || (state_nxt == ST_CRC_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      init_reg            <= CRC_STATE_INIT_DEFAULT;
      lfsr                <= CRC_STATE_INIT_DEFAULT;
      bit_cnt             <= 5'd0;
      pace_cnt            <= 8'd0;
      data_out            <= 1'b0;
      data_out_valid      <= 1'b0;
      data_out_valid_last <= 1'b0;
      busy                <= 1'b0;
    end else begin
      state               <= state_nxt;
      init_reg            <= init_nxt;
      lfsr                <= lfsr_nxt;
      bit_cnt             <= bit_cnt_nxt;
      pace_cnt            <= pace_cnt_nxt;
      data_out            <= dout_nxt;
      data_out_valid      <= dv_nxt;
      data_out_valid_last <= dvl_nxt;
      busy                <= busy_nxt;
    end
  end

endmodule

// File: doc/crc24_append.md
# crc24_append

Bit-serial BLE CRC-24 generator that sits directly upstream of the whitening (scramble) stage in the TX chain. It passes PDU bits through with one-cycle latency and updates the CRC LFSR on each bit. After the last PDU bit it emits the 24 CRC bits at the same bit pacing and marks the final CRC bit with a last strobe. Its output port set matches the whitening stage's `data_in` / `data_in_valid` / `data_in_valid_last` inputs.

## Interface
- `BIT_PERIOD_CLK`, 16: clocks between successive CRC output bits (16 = 1 Mbit/s at 16 MHz); legal range 2..255.
- `CRC_STATE_INIT_DEFAULT`, 24'h555555: reset value of the init register (advertising-channel init).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `crc_state_init_bit`  in  24  CRC init value; bit 0 maps to LFSR position 0.
- `crc_state_init_bit_load`  in  1  one-cycle strobe; latches `crc_state_init_bit` into init register and LFSR.
- `data_in`  in  1  PDU bit, LSB-first order as transmitted.
- `data_in_valid`  in  1  one-cycle strobe qualifying `data_in`.
- `data_in_valid_last`  in  1  marks final PDU bit; only meaningful with `data_in_valid`.
- `data_out`  out  1  PDU bit or CRC bit.
- `data_out_valid`  out  1  one-cycle strobe qualifying `data_out`.
- `data_out_valid_last`  out  1  high with `data_out_valid` on the 24th CRC bit only.
- `busy`  out  1  high while in CRC_OUT.

## Operation
- LFSR s[23:0]. Polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1.
- LFSR step per input bit:
  - fb = din ^ s[23]
  - s[0] ← fb
  - s[i] ← s[i-1] ^ fb for i ∈ {1,3,4,6,9,10}
  - s[i] ← s[i-1] for all other i.
- FSM has two states.
- IDLE/PASS:
  - On `data_in_valid`: the LFSR steps with `data_in`, and the bit is forwarded.
  - If `data_in_valid_last` is also high, go to CRC_OUT and clear the CRC bit counter (5 bits) and the pacing counter (8 bits).
- CRC_OUT:
  - Every `BIT_PERIOD_CLK` clocks, output s[23] and shift the LFSR left (s[i] ← s[i-1], s[0] ← 0). This emits the CRC MSB-first: position 23 first, position 0 last.
  - The 24th bit asserts `data_out_valid_last`. Then reload the LFSR from the init register and return to IDLE.
- `data_in_valid` while in CRC_OUT is dropped: no output, no LFSR change.
- `crc_state_init_bit_load`:
  - In IDLE: updates the init register and the LFSR.
  - In CRC_OUT: updates the init register only; the LFSR takes the new value at packet end.
  - If it coincides with `data_in_valid` in IDLE, the load wins and the data bit is still forwarded, but it does not enter the CRC.
- `data_in_valid_last` without `data_in_valid` is ignored.
- A single-bit packet (valid + last on the first bit) is legal.

## Timing
- All outputs are registered.
- Reset values:
  - `data_out`, `data_out_valid`, `data_out_valid_last`, `busy` = 0.
  - State = IDLE.
  - Init register and LFSR = `CRC_STATE_INIT_DEFAULT`.
  - Counters = 0.
- Asserting `rst` mid-packet aborts immediately. No `data_out_valid_last` is emitted, and the next packet starts clean.
- Pass-through latency: `data_out_valid` and `data_out` appear on the edge after the `data_in_valid` edge.
- `busy` rises on the same edge that outputs the last PDU bit.
- First CRC bit: `data_out_valid` pulses exactly `BIT_PERIOD_CLK` clocks after the last PDU bit's `data_out_valid`. Consecutive CRC bits are `BIT_PERIOD_CLK` clocks apart.
- `busy` falls on the edge after the 24th CRC bit's output edge. A `data_in_valid` on that following cycle is accepted normally.
- Upstream must space `data_in_valid` by ≥1 idle cycle. Behaviour under back-to-back strobes is still defined: every strobe is processed.
- Every strobe output is exactly one cycle wide.

## Test plan
- Init 0x000000, PDU = 8 zero bits → 8 zeros passed through, then 24 CRC zeros; `data_out_valid_last` on output #32 only.
- Init 0x555555, PDU = single bit 0 → output 0, then CRC (LFSR 0xAAAAAA) = 1,0,1,0,… (24 bits, starting 1); first CRC bit exactly 16 clocks after the data bit.
- Init 0x000000, PDU = single bit 1 → LFSR 0x00065B; CRC output = 13 zeros then 1,1,0,0,1,0,1,1,0,1,1.
- Two back-to-back packets: the same 40-bit random PDU sent twice with a load of 0x555555 only before the first → both CRCs identical and equal to the Python model's CRC. This checks the reload-at-end behaviour.
- `data_in_valid` during CRC_OUT, and `crc_state_init_bit_load` of 0x000000 during CRC_OUT → stray bit not output; current CRC unchanged; next packet uses 0x000000.
- Assert `rst` at CRC bit 10 → all outputs 0 within the reset, no last strobe; a subsequent packet with default init matches the reference vector from the scramble-stage test input.
